// File: rtl/seven_seg_pkg.sv
// ---------------------------------------------------------------------------
// seven_seg_pkg
// Shared definitions for the seven-segment display path: the hex glyph table
// (segments a..g in bits 6..0, active high), the dash glyph, the decode-kind
// enum, the capture FSM state enum and the glyph decode function.
// ---------------------------------------------------------------------------
package seven_seg_pkg;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'b1111110,  // 0
        7'b0110000,  // 1
        7'b1101101,  // 2
        7'b1111001,  // 3
        7'b0110011,  // 4
        7'b1011011,  // 5
        7'b1011111,  // 6
        7'b1110000,  // 7
        7'b1111111,  // 8
        7'b1111011,  // 9
        7'b1110111,  // A
        7'b0011111,  // b
        7'b1001110,  // C
        7'b0111101,  // d
        7'b1001111,  // E
        7'b1000111   // F
    };

    localparam logic [6:0] SEG_DASH = 7'b0000001;

    typedef enum logic [1:0] {
        HEX,
        DASH,
        ILLEGAL
    } seg_kind_e;

    typedef enum logic {
        IDLE,
        HAVE_HI
    } cap_state_e;

    typedef struct packed {
        seg_kind_e  kind;
        logic [3:0] nibble;
    } seg_decode_t;

    // Reverse lookup of a segment pattern; anything that is neither a hex
    // glyph nor the dash is reported as ILLEGAL with a zero nibble.
    function automatic seg_decode_t seg_decode(input logic [6:0] led);
        seg_decode_t d;
        d.kind   = ILLEGAL;
        d.nibble = 4'h0;
        if (led == SEG_DASH) begin
            d.kind = DASH;
        end
        for (int i = 0; i < 16; i++) begin
            if (led == SEG_HEX[i]) begin
                d.kind   = HEX;
                d.nibble = 4'(i);
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/seven_seg_capture_if.sv
// ---------------------------------------------------------------------------
// seven_seg_capture_if
// Bundles the multiplexed segment bus and the capture results.
//   seg_in      : {anode, led[6:0]}, anode=1 left (high) digit
//   value_out   : last reassembled byte {hi, lo}
//   value_valid : one-cycle pulse when value_out updates
//   dash_seen   : level, last accepted left digit was the dash
//   err         : one-cycle pulse on an accepted illegal pattern
// master = side that drives the display bus, slave = the capture block.
// ---------------------------------------------------------------------------
interface seven_seg_capture_if;
    logic [7:0] seg_in;
    logic [7:0] value_out;
    logic       value_valid;
    logic       dash_seen;
    logic       err;

    modport master (
        output seg_in,
        input  value_out,
        input  value_valid,
        input  dash_seen,
        input  err
    );

    modport slave (
        input  seg_in,
        output value_out,
        output value_valid,
        output dash_seen,
        output err
    );
endinterface

// File: rtl/seg_stable_filter.sv
// ---------------------------------------------------------------------------
// seg_stable_filter
// Registers the segment bus and accepts a pattern once it has been stable
// for STABLE_CYCLES consecutive samples.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_seg      : raw {anode, led} bus
//   o_seg      : registered pattern
//   o_accept   : one-cycle strobe, aligned with o_seg holding the pattern
// ---------------------------------------------------------------------------
module seg_stable_filter #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_seg,
    output logic [7:0] o_seg,
    output logic       o_accept
);

    localparam logic [4:0] STABLE = 5'(STABLE_CYCLES);

    logic [7:0] r_seg_q;
    logic [4:0] r_run_cnt;
    logic       r_accept;

    // r_run_cnt is only ever zero straight after reset, so it doubles as the
    // "first sample" marker. The strobe fires on the single S-1 -> S step and
    // the saturated count prevents a second accept within the same run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_q   <= 8'h00;
            r_run_cnt <= 5'd0;
            r_accept  <= 1'b0;
        end else begin
            r_seg_q  <= i_seg;
            r_accept <= 1'b0;
            if ((i_seg != r_seg_q) || (r_run_cnt == 5'd0)) begin
                r_run_cnt <= 5'd1;
            end else if (r_run_cnt != STABLE) begin
                r_run_cnt <= r_run_cnt + 5'd1;
                if (r_run_cnt == STABLE - 5'd1) begin
                    r_accept <= 1'b1;
                end
            end
        end
    end

    assign o_seg    = r_seg_q;
    assign o_accept = r_accept;

endmodule

// File: rtl/seven_seg_capture.sv
// ---------------------------------------------------------------------------
// seven_seg_capture
// Receive-side monitor for the multiplexed seven-segment display bus.
// Debounces each displayed pattern, decodes it back to a hex nibble and
// pairs a left digit with the following right digit into a byte.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : seven_seg_capture_if.slave (seg_in in; value_out,
//                value_valid, dash_seen, err out)
// ---------------------------------------------------------------------------
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    seven_seg_capture_if.slave  bus
);

    logic [7:0]  w_seg;
    logic        w_accept;
    logic        w_anode;
    seg_decode_t w_dec;

    cap_state_e  r_state;
    logic [3:0]  r_hi;
    logic [7:0]  r_value;
    logic        r_valid;
    logic        r_dash;
    logic        r_err;

    seg_stable_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_seg    (bus.seg_in),
        .o_seg    (w_seg),
        .o_accept (w_accept)
    );

    assign w_anode = w_seg[7];
    assign w_dec   = seg_decode(w_seg[6:0]);

    // Pairing FSM. Everything moves only on an accept strobe. An illegal
    // pattern wins over every other transition, so err and value_valid can
    // never pulse together. A right-digit dash is not a completion and is
    // simply ignored in both states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_hi    <= 4'h0;
            r_value <= 8'h00;
            r_valid <= 1'b0;
            r_dash  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (w_accept) begin
                if (w_dec.kind == ILLEGAL) begin
                    r_err   <= 1'b1;
                    r_hi    <= 4'h0;
                    r_state <= IDLE;
                end else begin
                    case (r_state)
                        IDLE: begin
                            if (w_anode && (w_dec.kind == HEX)) begin
                                r_hi    <= w_dec.nibble;
                                r_dash  <= 1'b0;
                                r_state <= HAVE_HI;
                            end else if (w_anode && (w_dec.kind == DASH)) begin
                                r_dash <= 1'b1;
                            end
                        end
                        HAVE_HI: begin
                            if (!w_anode && (w_dec.kind == HEX)) begin
                                r_value <= {r_hi, w_dec.nibble};
                                r_valid <= 1'b1;
                                r_hi    <= 4'h0;
                                r_state <= IDLE;
                            end else if (w_anode && (w_dec.kind == HEX)) begin
                                r_hi    <= w_dec.nibble;
                                r_dash  <= 1'b0;
                            end else if (w_anode && (w_dec.kind == DASH)) begin
                                r_dash  <= 1'b1;
                                r_hi    <= 4'h0;
                                r_state <= IDLE;
                            end
                        end
                        default: begin
                            r_state <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.value_out   = r_value;
    assign bus.value_valid = r_valid;
    assign bus.dash_seen   = r_dash;
    assign bus.err         = r_err;

endmodule

// File: tb/tb_seven_seg_capture.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_capture
// Directed bench for seven_seg_capture with STABLE_CYCLES = 4. Glyphs and
// expected bytes are written out by hand below.
// ---------------------------------------------------------------------------
module tb_seven_seg_capture;

    localparam logic [6:0] G0    = 7'b1111110;
    localparam logic [6:0] G1    = 7'b0110000;
    localparam logic [6:0] G3    = 7'b1111001;
    localparam logic [6:0] G5    = 7'b1011011;
    localparam logic [6:0] G7    = 7'b1110000;
    localparam logic [6:0] GA    = 7'b1110111;
    localparam logic [6:0] GC    = 7'b1001110;
    localparam logic [6:0] GE    = 7'b1001111;
    localparam logic [6:0] GF    = 7'b1000111;
    localparam logic [6:0] GDASH = 7'b0000001;
    localparam logic [6:0] GNONE = 7'b0000000;

    logic clk;
    logic rst_n;

    int testsRun     = 0;
    int testsFailed  = 0;
    int cycleNum     = 0;
    int validCount   = 0;
    int errCount     = 0;
    int overlapCount = 0;
    int lastValidCycle = 0;
    int onsetCycle   = 0;
    int v0;
    int e0;

    seven_seg_capture_if bus();

    seven_seg_capture #(
        .STABLE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle index used to measure output latency.
    always @(posedge clk) begin
        cycleNum <= cycleNum + 1;
    end

    // Pulse monitor, sampled on the falling edge away from the active edge.
    always @(negedge clk) begin
        if (bus.value_valid === 1'b1) begin
            validCount     = validCount + 1;
            lastValidCycle = cycleNum;
        end
        if (bus.err === 1'b1) begin
            errCount = errCount + 1;
        end
        if (bus.value_valid === 1'b1 && bus.err === 1'b1) begin
            overlapCount = overlapCount + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun = testsRun + 1;
        if (actual !== expected) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one pattern starting just after a rising edge and hold it for
    // the given number of cycles.
    task automatic applyStimulus(input logic anode, input logic [6:0] led,
                                 input int cycles);
        bus.seg_in = {anode, led};
        onsetCycle = cycleNum;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.seg_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset value_out",   32'(bus.value_out),   32'h00);
        checkOutput("reset value_valid", 32'(bus.value_valid), 32'h0);
        checkOutput("reset dash_seen",   32'(bus.dash_seen),   32'h0);
        checkOutput("reset err",         32'(bus.err),         32'h0);

        // Phase alignment: a lone right digit first, then a full 0x0F pair.
        rst_n = 1'b1;
        v0 = validCount; e0 = errCount;
        applyStimulus(1'b0, GF, 32);
        checkOutput("lone right after reset", 32'(validCount - v0), 32'd0);
        applyStimulus(1'b1, G0, 32);
        applyStimulus(1'b0, GF, 32);
        checkOutput("phase valid count", 32'(validCount - v0), 32'd1);
        checkOutput("phase value",       32'(bus.value_out),   32'h0F);
        checkOutput("phase err count",   32'(errCount - e0),   32'd0);

        // Nominal byte 0xA5 with latency from right-digit onset.
        v0 = validCount;
        applyStimulus(1'b1, GA, 32);
        applyStimulus(1'b0, G5, 32);
        checkOutput("nominal valid count", 32'(validCount - v0), 32'd1);
        checkOutput("nominal value",       32'(bus.value_out),   32'hA5);
        checkOutput("nominal latency",     32'(lastValidCycle - onsetCycle), 32'd5);

        // Glitch: a 3-cycle right digit during HAVE_HI is rejected.
        v0 = validCount; e0 = errCount;
        applyStimulus(1'b1, GA, 32);
        applyStimulus(1'b0, G1, 3);
        applyStimulus(1'b1, GA, 32);
        checkOutput("glitch valid count", 32'(validCount - v0), 32'd0);
        checkOutput("glitch err count",   32'(errCount - e0),   32'd0);

        // Dash on the left digit, then a 0x3C pair clears it.
        v0 = validCount;
        applyStimulus(1'b1, GDASH, 32);
        checkOutput("dash seen",        32'(bus.dash_seen),    32'h1);
        checkOutput("dash valid count", 32'(validCount - v0), 32'd0);
        applyStimulus(1'b0, GC, 32);
        checkOutput("dash then right",  32'(validCount - v0), 32'd0);
        applyStimulus(1'b1, G3, 32);
        checkOutput("dash cleared",     32'(bus.dash_seen),    32'h0);
        applyStimulus(1'b0, GC, 32);
        checkOutput("dash pair value",  32'(bus.value_out),    32'h3C);
        checkOutput("dash pair count",  32'(validCount - v0), 32'd1);

        // Illegal right pattern in HAVE_HI, then a lone right digit.
        v0 = validCount; e0 = errCount;
        applyStimulus(1'b1, GA, 32);
        applyStimulus(1'b0, GNONE, 32);
        checkOutput("illegal err count",   32'(errCount - e0),   32'd1);
        checkOutput("illegal valid count", 32'(validCount - v0), 32'd0);
        applyStimulus(1'b0, G5, 32);
        checkOutput("illegal then right",  32'(validCount - v0), 32'd0);
        checkOutput("illegal keeps value", 32'(bus.value_out),   32'h3C);

        // Reset in HAVE_HI: outputs clear without waiting for an edge.
        v0 = validCount;
        applyStimulus(1'b1, GA, 32);
        rst_n = 1'b0;
        #1;
        checkOutput("async reset value_out", 32'(bus.value_out), 32'h00);
        checkOutput("async reset dash_seen", 32'(bus.dash_seen), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b0, G5, 32);
        checkOutput("reset lone right", 32'(validCount - v0), 32'd0);
        applyStimulus(1'b1, G5, 32);
        applyStimulus(1'b0, GA, 32);
        checkOutput("reset pair value", 32'(bus.value_out),   32'h5A);
        checkOutput("reset pair count", 32'(validCount - v0), 32'd1);

        // Digits held exactly STABLE_CYCLES cycles are still accepted.
        v0 = validCount;
        applyStimulus(1'b1, G7, 4);
        applyStimulus(1'b0, GE, 4);
        applyStimulus(1'b0, GE, 10);
        checkOutput("min hold value", 32'(bus.value_out),   32'h7E);
        checkOutput("min hold count", 32'(validCount - v0), 32'd1);

        checkOutput("valid/err overlap", 32'(overlapCount), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
